// File: rtl/ring_shifter.sv
// ring_shifter: WIDTH-bit rotate/shift register with serial or sticky fill,
// a step counter modulo WIDTH and a registered wrap pulse.
// Optional feature macro: RING_SHIFTER_BOUNCE_EN adds the 'bounce' input and
// an internal direction register that reverses a rotate when a 1 would exit.
module ring_shifter #(
  parameter int                 WIDTH = 8,
  parameter logic [WIDTH-1:0]   INIT  = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      load,
  input  logic [WIDTH-1:0]          data,
  input  logic                      en,
  input  logic                      dir,
  input  logic [1:0]                mode,
  input  logic                      sin,
`ifdef RING_SHIFTER_BOUNCE_EN
  input  logic                      bounce,
`endif
  output logic [WIDTH-1:0]          count,
  output logic                      sout,
  output logic [$clog2(WIDTH)-1:0]  step_cnt,
  output logic                      wrap
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] M_ROT  = 2'b00;
  localparam logic [1:0] M_SIN  = 2'b01;
  localparam logic [1:0] M_STKY = 2'b10;

  logic [WIDTH-1:0] r_count;
  logic             r_sout;
  logic [CW-1:0]    r_step_cnt;
  logic             r_wrap;

  logic             w_step;
  logic             w_dir;
  logic             w_exit;
  logic             w_fill;
  logic             w_last;
  logic [WIDTH-1:0] w_next;

`ifdef RING_SHIFTER_BOUNCE_EN
  logic r_dir_q;
  logic w_bounce;
  logic w_qexit;

  // Bounce: rotate follows dir_q, flipping it first if the bit about to leave is a 1.
  always_comb begin
    w_bounce = bounce && (mode == M_ROT);
    w_qexit  = r_dir_q ? r_count[WIDTH-1] : r_count[0];
    w_dir    = dir;
    if (w_bounce) w_dir = w_qexit ? ~r_dir_q : r_dir_q;
  end

  // Direction register tracks the direction actually used by each step.
  always_ff @(posedge clk) begin
    if (reset)               r_dir_q <= 1'b1;
    else if (!load && w_step) r_dir_q <= w_dir;
  end
`else
  assign w_dir = dir;
`endif

  // Step datapath: exit bit, fill bit and shifted value for the chosen direction.
  always_comb begin
    w_step = en && (mode != 2'b11);
    w_exit = w_dir ? r_count[WIDTH-1] : r_count[0];
    case (mode)
      M_ROT:   w_fill = w_exit;
      M_SIN:   w_fill = sin;
      M_STKY:  w_fill = w_dir ? r_count[0] : r_count[WIDTH-1];
      default: w_fill = w_exit;
    endcase
    w_next = w_dir ? {r_count[WIDTH-2:0], w_fill} : {w_fill, r_count[WIDTH-1:1]};
    w_last = (r_step_cnt == CW'(WIDTH-1));
  end

  // Main register: reset > load > step; wrap only ever lasts one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count    <= INIT;
      r_sout     <= 1'b0;
      r_step_cnt <= '0;
      r_wrap     <= 1'b0;
    end else if (load) begin
      r_count    <= data;
      r_sout     <= 1'b0;
      r_step_cnt <= '0;
      r_wrap     <= 1'b0;
    end else if (w_step) begin
      r_count    <= w_next;
      r_sout     <= w_exit;
      r_step_cnt <= w_last ? '0 : r_step_cnt + 1'b1;
      r_wrap     <= w_last;
    end else begin
      r_wrap     <= 1'b0;
    end
  end

  assign count    = r_count;
  assign sout     = r_sout;
  assign step_cnt = r_step_cnt;
  assign wrap     = r_wrap;

endmodule

// File: tb/tb_ring_shifter.sv
// Directed bench for ring_shifter (WIDTH=8, INIT=8'h01).
module tb_ring_shifter;

  logic       clk = 1'b0;
  logic       reset, load, en, dir, sin;
  logic [7:0] data;
  logic [1:0] mode;
`ifdef RING_SHIFTER_BOUNCE_EN
  logic       bounce;
`endif
  logic [7:0] count;
  logic       sout;
  logic [2:0] step_cnt;
  logic       wrap;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  ring_shifter #(.WIDTH(8), .INIT(8'h01)) dut (
    .clk(clk), .reset(reset), .load(load), .data(data), .en(en),
    .dir(dir), .mode(mode), .sin(sin),
`ifdef RING_SHIFTER_BOUNCE_EN
    .bounce(bounce),
`endif
    .count(count), .sout(sout), .step_cnt(step_cnt), .wrap(wrap)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance one rising edge, then settle away from it.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk_state(input string tag, input logic [7:0] c, input logic [2:0] s,
                           input logic so, input logic w);
    chk({tag, ".count"}, 64'(count), 64'(c));
    chk({tag, ".step"},  64'(step_cnt), 64'(s));
    chk({tag, ".sout"},  64'(sout), 64'(so));
    chk({tag, ".wrap"},  64'(wrap), 64'(w));
  endtask

  initial begin
    int wraps;
    reset = 1; load = 0; en = 0; dir = 1; sin = 0; data = '0; mode = 2'b00;
`ifdef RING_SHIFTER_BOUNCE_EN
    bounce = 0;
`endif
    tick(); tick();
    chk_state("reset", 8'h01, 3'd0, 1'b0, 1'b0);

    // First step right after reset release: rotate left.
    reset = 0; en = 1; mode = 2'b00; dir = 1;
    tick(); en = 0;
    chk_state("rotl1", 8'h02, 3'd1, 1'b0, 1'b0);
    tick();
    chk_state("idle", 8'h02, 3'd1, 1'b0, 1'b0);

    // Load then serial fill left with sin=1.
    load = 1; data = 8'h81; tick(); load = 0;
    chk_state("load81", 8'h81, 3'd0, 1'b0, 1'b0);
    en = 1; mode = 2'b01; dir = 1; sin = 1; tick();
    chk_state("sinl", 8'h03, 3'd1, 1'b1, 1'b0);
    // Sticky right from 03: MSB 0 replicated, LSB 1 exits.
    mode = 2'b10; dir = 0; tick(); en = 0;
    chk_state("stkr03", 8'h01, 3'd2, 1'b1, 1'b0);
    // Sticky right from 81: MSB 1 replicated.
    load = 1; data = 8'h81; tick(); load = 0;
    en = 1; mode = 2'b10; dir = 0; tick(); en = 0;
    chk_state("stkr81", 8'hC0, 3'd1, 1'b1, 1'b0);
    // Sticky left from 81: LSB 1 replicated, MSB 1 exits.
    load = 1; data = 8'h81; tick(); load = 0;
    en = 1; mode = 2'b10; dir = 1; tick(); en = 0;
    chk_state("stkl81", 8'h03, 3'd1, 1'b1, 1'b0);
    // Serial fill right with sin=0 from 03.
    en = 1; mode = 2'b01; dir = 0; sin = 0; tick(); en = 0;
    chk_state("sinr", 8'h01, 3'd2, 1'b1, 1'b0);
    // Rotate right from 01: LSB wraps to MSB.
    en = 1; mode = 2'b00; dir = 0; tick(); en = 0;
    chk_state("rotr", 8'h80, 3'd3, 1'b1, 1'b0);

    // Two consecutive full laps: exactly one wrap pulse per lap.
    reset = 1; tick(); reset = 0;
    en = 1; mode = 2'b00; dir = 1; wraps = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (wrap) wraps++;
      chk($sformatf("lap.step%0d", i + 1), 64'(step_cnt), 64'((i + 1) % 8));
      chk($sformatf("lap.wrap%0d", i + 1), 64'(wrap), 64'((i == 7 || i == 15) ? 1 : 0));
    end
    en = 0;
    chk("lap.count", 64'(count), 64'h01);
    chk("lap.npulse", 64'(wraps), 64'd2);
    tick();
    chk("wrapdrop", 64'(wrap), 64'd0);

    // load beats en in the same cycle.
    load = 1; en = 1; data = 8'hF0; tick(); load = 0; en = 0;
    chk_state("loaden", 8'hF0, 3'd0, 1'b0, 1'b0);

    // Reset on the 5th rotate edge overrides load and en.
    reset = 1; tick(); reset = 0;
    en = 1; mode = 2'b00; dir = 1;
    repeat (4) tick();
    chk("pre5.count", 64'(count), 64'h10);
    reset = 1; load = 1; data = 8'hAA; tick(); reset = 0; load = 0; en = 0;
    chk_state("rst5", 8'h01, 3'd0, 1'b0, 1'b0);

    // Reset on the wrapping 8th edge suppresses the pulse.
    en = 1;
    repeat (7) tick();
    chk("pre8.step", 64'(step_cnt), 64'd7);
    reset = 1; tick(); reset = 0; en = 0;
    chk_state("rst8", 8'h01, 3'd0, 1'b0, 1'b0);
    tick();
    chk("rst8.wrap2", 64'(wrap), 64'd0);

    // Mode 11 with en: full hold, sout retained.
    load = 1; data = 8'h81; tick(); load = 0;
    en = 1; mode = 2'b00; dir = 1; tick();
    chk_state("prehold", 8'h03, 3'd1, 1'b1, 1'b0);
    mode = 2'b11;
    for (int i = 0; i < 3; i++) begin
      dir = i[0];
      tick();
      chk_state($sformatf("hold%0d", i), 8'h03, 3'd1, 1'b1, 1'b0);
    end
    en = 0;

`ifdef RING_SHIFTER_BOUNCE_EN
    // Bounce: 40 -> 80 -> (1 exits, flip) 40 -> 20; dir input held at 1.
    reset = 1; tick(); reset = 0;
    load = 1; data = 8'h40; tick(); load = 0;
    bounce = 1; mode = 2'b00; dir = 1; en = 1;
    tick(); chk("bnc1", 64'(count), 64'h80);
    tick(); chk("bnc2", 64'(count), 64'h40);
    chk("bnc2.dirq", 64'(dut.r_dir_q), 64'd0);
    chk("bnc2.sout", 64'(sout), 64'd0);
    tick(); chk("bnc3", 64'(count), 64'h20);
    en = 0; bounce = 0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  // Hard stop in case something stalls the sequence.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
